// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and address-width helper for the register file
package reg_file_pkg;

    localparam int DEFAULT_WORDSIZE  = 24;
    localparam int DEFAULT_BLOCKSIZE = 64;

    // Never returns less than 1 so a degenerate depth still yields a legal port width.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// rtl/reg_file_rdport.sv - one combinational read multiplexer with out-of-range masking
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int WORDSIZE  = DEFAULT_WORDSIZE,
    parameter int BLOCKSIZE = DEFAULT_BLOCKSIZE,
    parameter int ADR       = addr_width(BLOCKSIZE)
) (
    input  logic [WORDSIZE-1:0] mem [BLOCKSIZE],
    input  logic [ADR-1:0]      addr,
    output logic [WORDSIZE-1:0] data
);

    always_comb begin
        data = '0;
        if (int'(addr) < BLOCKSIZE) begin
            data = mem[addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - flip-flop register file, one write port and two combinational read ports
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int WORDSIZE  = DEFAULT_WORDSIZE,
    parameter  int BLOCKSIZE = DEFAULT_BLOCKSIZE,
    localparam int ADR       = addr_width(BLOCKSIZE)
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [ADR-1:0]      AW,
    input  logic [ADR-1:0]      AR,
    input  logic [ADR-1:0]      BR,
    input  logic                WE,
    input  logic [WORDSIZE-1:0] D,
    output logic [WORDSIZE-1:0] A,
    output logic [WORDSIZE-1:0] B
);

    logic [WORDSIZE-1:0] mem_q [BLOCKSIZE];
    logic [WORDSIZE-1:0] mem_d [BLOCKSIZE];

    // Out-of-range write addresses leave the array untouched.
    always_comb begin
        mem_d = mem_q;
        if (WE && (int'(AW) < BLOCKSIZE)) begin
            mem_d[AW] = D;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < BLOCKSIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads come straight off the flops, so a same-cycle write is seen only after the edge.
    reg_file_rdport #(
        .WORDSIZE  (WORDSIZE),
        .BLOCKSIZE (BLOCKSIZE),
        .ADR       (ADR)
    ) u_rdport_a (
        .mem  (mem_q),
        .addr (AR),
        .data (A)
    );

    reg_file_rdport #(
        .WORDSIZE  (WORDSIZE),
        .BLOCKSIZE (BLOCKSIZE),
        .ADR       (ADR)
    ) u_rdport_b (
        .mem  (mem_q),
        .addr (BR),
        .data (B)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

    localparam int WS  = 24;
    localparam int BS  = 64;
    localparam int ADR = 6;

    logic           CLK;
    logic           RSTN;
    logic [ADR-1:0] AW;
    logic [ADR-1:0] AR;
    logic [ADR-1:0] BR;
    logic           WE;
    logic [WS-1:0]  D;
    logic [WS-1:0]  A;
    logic [WS-1:0]  B;

    int errors = 0;
    int checks = 0;

    reg_file #(
        .WORDSIZE  (WS),
        .BLOCKSIZE (BS)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .AW   (AW),
        .AR   (AR),
        .BR   (BR),
        .WE   (WE),
        .D    (D),
        .A    (A),
        .B    (B)
    );

    // Starts high so rising edges land at 80, 160, 240 ns.
    initial begin
        CLK = 1'b1;
        forever #40 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTN = 1'b0; WE = 1'b0; AW = '0; AR = '0; BR = '0; D = '0;
        #10;
        check_eq("reset_a", A, 24'd0);
        check_eq("reset_b", B, 24'd0);
        #10 RSTN = 1'b1;
        AR = 6'd24; BR = 6'd25;
        #1;
        check_eq("post_reset_a24", A, 24'd0);
        check_eq("post_reset_b25", B, 24'd0);

        @(posedge CLK); #1;
        AW = 6'd24; D = 24'd8596; WE = 1'b1;
        #77;
        check_eq("collide_pre_edge_a", A, 24'd0);
        @(posedge CLK); #1;
        check_eq("write24_a", A, 24'd8596);

        AW = 6'd25; D = 24'd72145;
        #77;
        check_eq("collide_pre_edge_b", B, 24'd0);
        @(posedge CLK); #1;
        WE = 1'b0;
        check_eq("write25_b", B, 24'd72145);
        check_eq("entry24_kept", A, 24'd8596);

        AR = 6'd10; #1;
        check_eq("ar10", A, 24'd0);
        AR = 6'd25; #1;
        check_eq("ar25", A, 24'd72145);
        AR = 6'd24; #1;
        check_eq("ar24", A, 24'd8596);
        check_eq("b_unaffected", B, 24'd72145);

        D = 24'd123; AW = 6'd24;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("we0_entry24", A, 24'd8596);
        check_eq("we0_entry25", B, 24'd72145);
        AR = 6'd10; #1;
        check_eq("we0_entry10", A, 24'd0);

        AR = 6'd25; BR = 6'd25; #1;
        check_eq("same_addr_a", A, 24'd72145);
        check_eq("same_addr_b", B, 24'd72145);
        AR = 6'd24;

        #20 RSTN = 1'b0;
        #1;
        check_eq("async_reset_a", A, 24'd0);
        check_eq("async_reset_b", B, 24'd0);
        AW = 6'd24; D = 24'd555; WE = 1'b1;
        @(posedge CLK); #1;
        check_eq("reset_blocks_write", A, 24'd0);
        #10 RSTN = 1'b1;
        #1;
        check_eq("release_entry24", A, 24'd0);
        check_eq("release_entry25", B, 24'd0);
        @(posedge CLK); #1;
        check_eq("first_write_after_reset", A, 24'd555);
        check_eq("neighbour_untouched", B, 24'd0);

        AW = 6'd63; D = 24'hFFFFFF;
        @(posedge CLK); #1;
        WE = 1'b0;
        AR = 6'd63; BR = 6'd0; #1;
        check_eq("top_entry63", A, 24'hFFFFFF);
        check_eq("entry0_untouched", B, 24'd0);
        BR = 6'd24; #1;
        check_eq("entry24_after_63", B, 24'd555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
